// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: deframer states, entry layout
// and the parity check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_PUSH   = 3'd4
    } rx_state_e;

    // Flag positions above the data field; add DATA_BITS for the absolute index.
    localparam int OE_BIT    = 0;
    localparam int BE_BIT    = 1;
    localparam int FE_BIT    = 2;
    localparam int PE_BIT    = 3;
    localparam int FLAG_BITS = 4;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    function automatic logic parity_error(input logic data_xor, input logic par_bit,
                                          input logic odd_mode);
        return ((data_xor ^ par_bit) != odd_mode);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: storage, wrapping pointers, registered count and
// flags, and a registered read port with a one-cycle valid pulse.
module sync_fifo_ctrl #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    import uart_pkg::*;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             empty_r;
    logic             full_r;
    logic             rd_valid_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             push_s;
    logic             pop_s;

    // DEPTH need not be a power of two, so the wrap is explicit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Pop when data exists; a write into a full FIFO only proceeds alongside a pop.
    always_comb begin
        pop_s        = rd_en && !empty_r;
        push_s       = wr_en && (!full_r || pop_s);
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, status and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r  <= ptr_inc(rd_ptr_r);
                rd_data_r <= mem_r[rd_ptr_r];
            end
            rd_valid_r <= pop_s;
            count_r    <= count_next_s;
            empty_r    <= (count_next_s == CNT_W'(0));
            full_r     <= (count_next_s == CNT_W'(DEPTH));
        end
    end

    // Storage array; contents survive reset but become unreachable.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign count    = count_r;

endmodule

// File: rtl/uart_rx_fifo_gen.sv
// UART receiver: deframes the serial line one sample per baud_clk, tags each frame
// with parity/framing/break/overrun flags and queues it in a receive FIFO.
module uart_rx_fifo_gen
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 16,
    parameter int BREAK_FRAMES = 3
) (
    input  logic                         baud_clk,
    input  logic                         rst,
    input  logic                         data_in,
    input  logic                         rd_en,
    output logic [DATA_BITS+3:0]         data_out,
    output logic                         data_valid,
    output logic                         RxFE,
    output logic                         RxFF,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overrun,
    output logic                         busy
);
    localparam int   ENTRY_W  = DATA_BITS + FLAG_BITS;
    localparam int   BRK_W    = $clog2(BREAK_FRAMES + 1);
    localparam logic ODD_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

    rx_state_e              state_r;
    rx_state_e              state_next_s;
    logic [3:0]             bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_r;
    logic                   stop_zero_r;
    logic                   stop_one_r;
    logic [BRK_W-1:0]       brk_cnt_r;
    logic                   oe_pend_r;
    logic                   overrun_r;
    logic                   busy_r;

    logic                   par_clear_s;
    logic                   pe_s;
    logic                   is_break_s;
    logic                   brk_hit_s;
    logic                   brk_drop_s;
    logic                   frame_req_s;
    logic                   wr_en_s;
    logic                   ovr_s;
    logic [ENTRY_W-1:0]     entry_s;

    // Next-state logic of the deframer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!data_in) state_next_s = ST_DATA;
                else          state_next_s = ST_IDLE;
            end
            ST_DATA: begin
                if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                    state_next_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: state_next_s = ST_STOP;
            ST_STOP: begin
                if (bit_cnt_r == 4'(STOP_BITS - 1)) state_next_s = ST_PUSH;
                else                                state_next_s = ST_STOP;
            end
            ST_PUSH: begin
                if (!data_in) state_next_s = ST_DATA;
                else          state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Frame classification and the write/overrun decision taken in PUSH.
    always_comb begin
        par_clear_s = 1'b1;
        pe_s        = 1'b0;
        if (PARITY_EN != 0) begin
            par_clear_s = !par_r;
            pe_s        = parity_error(^shift_r, par_r, ODD_MODE);
        end else begin
            par_clear_s = 1'b1;
            pe_s        = 1'b0;
        end
        is_break_s  = (shift_r == {DATA_BITS{1'b0}}) && par_clear_s && !stop_one_r;
        brk_hit_s   = is_break_s && (brk_cnt_r == BRK_W'(BREAK_FRAMES - 1));
        brk_drop_s  = is_break_s && (brk_cnt_r >= BRK_W'(BREAK_FRAMES));
        frame_req_s = (state_r == ST_PUSH) && !brk_drop_s;
        wr_en_s     = frame_req_s && (!RxFF || rd_en);
        ovr_s       = frame_req_s && !wr_en_s;

        entry_s                        = {ENTRY_W{1'b0}};
        entry_s[DATA_BITS-1:0]         = shift_r;
        entry_s[DATA_BITS + PE_BIT]    = pe_s;
        entry_s[DATA_BITS + FE_BIT]    = stop_zero_r;
        entry_s[DATA_BITS + BE_BIT]    = brk_hit_s;
        entry_s[DATA_BITS + OE_BIT]    = oe_pend_r;
    end

    // Deframer state and sample capture.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= {DATA_BITS{1'b0}};
            par_r       <= 1'b0;
            stop_zero_r <= 1'b0;
            stop_one_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE, ST_PUSH: begin
                    bit_cnt_r   <= 4'd0;
                    stop_zero_r <= 1'b0;
                    stop_one_r  <= 1'b0;
                end
                ST_DATA: begin
                    shift_r   <= {data_in, shift_r[DATA_BITS-1:1]};
                    bit_cnt_r <= (state_next_s == ST_DATA) ? bit_cnt_r + 4'd1 : 4'd0;
                end
                ST_PARITY: par_r <= data_in;
                ST_STOP: begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (!data_in) stop_zero_r <= 1'b1;
                    else          stop_one_r  <= 1'b1;
                end
                default: bit_cnt_r <= 4'd0;
            endcase
        end
    end

    // Break counting, pending-overrun flag and registered status pulses.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            brk_cnt_r <= {BRK_W{1'b0}};
            oe_pend_r <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            overrun_r <= ovr_s;
            busy_r    <= (state_next_s != ST_IDLE);
            if ((state_r == ST_IDLE) && data_in) begin
                brk_cnt_r <= {BRK_W{1'b0}};
            end else if (state_r == ST_PUSH) begin
                if (!is_break_s)      brk_cnt_r <= {BRK_W{1'b0}};
                else if (!brk_drop_s) brk_cnt_r <= brk_cnt_r + BRK_W'(1);
            end
            if (wr_en_s)    oe_pend_r <= 1'b0;
            else if (ovr_s) oe_pend_r <= 1'b1;
        end
    end

    sync_fifo_ctrl #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (baud_clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_data  (entry_s),
        .rd_en    (rd_en),
        .rd_data  (data_out),
        .rd_valid (data_valid),
        .empty    (RxFE),
        .full     (RxFF),
        .count    (count)
    );

    assign overrun = overrun_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
// Scoreboard bench: three receiver configurations driven with directed frames;
// expected entries are queued at send time and checked by per-instance monitors.
module tb_uart_rx_fifo_gen;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] line;
    logic [2:0] rd;

    int checks = 0;
    int errors = 0;

    logic [11:0] qa [$];
    logic [11:0] qb [$];
    logic [11:0] qc [$];

    logic [11:0] dout_a, dout_b;
    logic [10:0] dout_c;
    logic        dv_a, dv_b, dv_c, fe_a, fe_b, fe_c, ff_a, ff_b, ff_c;
    logic        ovr_a, ovr_b, ovr_c, busy_a, busy_b, busy_c;
    logic [4:0]  cnt_a, cnt_c;
    logic [2:0]  cnt_b;

    always #5 clk = ~clk;

    uart_rx_fifo_gen u_a (
        .baud_clk(clk), .rst(rst[0]), .data_in(line[0]), .rd_en(rd[0]),
        .data_out(dout_a), .data_valid(dv_a), .RxFE(fe_a), .RxFF(ff_a),
        .count(cnt_a), .overrun(ovr_a), .busy(busy_a));

    uart_rx_fifo_gen #(.PARITY_ODD(1), .DEPTH(4)) u_b (
        .baud_clk(clk), .rst(rst[1]), .data_in(line[1]), .rd_en(rd[1]),
        .data_out(dout_b), .data_valid(dv_b), .RxFE(fe_b), .RxFF(ff_b),
        .count(cnt_b), .overrun(ovr_b), .busy(busy_b));

    uart_rx_fifo_gen #(.DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(2)) u_c (
        .baud_clk(clk), .rst(rst[2]), .data_in(line[2]), .rd_en(rd[2]),
        .data_out(dout_c), .data_valid(dv_c), .RxFE(fe_c), .RxFF(ff_c),
        .count(cnt_c), .overrun(ovr_c), .busy(busy_c));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: data_valid with entry 0x%0h but no entry expected", name, act);
    endtask

    // Monitors: every data_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (dv_a) begin
            if (qa.size() == 0) unexpected("a_pop", int'(dout_a));
            else chk("a_pop", int'(dout_a), int'(qa.pop_front()));
        end
        if (dv_b) begin
            if (qb.size() == 0) unexpected("b_pop", int'(dout_b));
            else chk("b_pop", int'(dout_b), int'(qb.pop_front()));
        end
        if (dv_c) begin
            if (qc.size() == 0) unexpected("c_pop", int'(dout_c));
            else chk("c_pop", int'(dout_c), int'(qc.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input int k, input logic v);
        line[k] = v;
        tick();
    endtask

    task automatic send(input int k, input logic [8:0] d, input int nd, input logic pbit,
                        input int pen, input int ns, input logic sv);
        drive(k, 1'b0);
        for (int i = 0; i < nd; i++) drive(k, d[i]);
        if (pen != 0) drive(k, pbit);
        for (int i = 0; i < ns; i++) drive(k, sv);
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) drive(k, 1'b1);
    endtask

    task automatic pop(input int k);
        rd[k] = 1'b1;
        tick();
        rd[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        rst  = 3'b111;
        line = 3'b111;
        rd   = 3'b000;
        tick();
        tick();
        rst = 3'b000;
        sample();
        chk("rst_a_dout", int'(dout_a), 0);
        chk("rst_a_dv", int'(dv_a), 0);
        chk("rst_a_RxFE", int'(fe_a), 1);
        chk("rst_a_RxFF", int'(ff_a), 0);
        chk("rst_a_count", int'(cnt_a), 0);
        chk("rst_a_overrun", int'(ovr_a), 0);
        chk("rst_a_busy", int'(busy_a), 0);
        chk("rst_b_RxFE", int'(fe_b), 1);
        chk("rst_c_count", int'(cnt_c), 0);

        // A: 0xA5, even parity 0, one stop; entry lands at the edge ending PUSH.
        qa.push_back(12'h0A5);
        send(0, 9'h0A5, 8, 1'b0, 1, 1, 1'b1);
        chk("a_busy_frame", int'(busy_a), 1);
        sample();
        chk("a_RxFE_before_push", int'(fe_a), 1);
        sample();
        chk("a_RxFE_after_push", int'(fe_a), 0);
        chk("a_count_one", int'(cnt_a), 1);
        chk("a_busy_idle", int'(busy_a), 0);
        pop(0);
        pop(0);
        sample();
        chk("a_dout_held", int'(dout_a), 12'h0A5);
        chk("a_RxFE_drained", int'(fe_a), 1);

        // A: line low for four frames -> FE, FE, FE+BE, then discarded.
        qa.push_back(12'h400);
        qa.push_back(12'h400);
        qa.push_back(12'h600);
        for (int i = 0; i < 4; i++) send(0, 9'h000, 8, 1'b0, 1, 1, 1'b0);
        idle(0, 2);
        sample();
        chk("a_break_count", int'(cnt_a), 3);
        qa.push_back(12'h03C);
        send(0, 9'h03C, 8, 1'b0, 1, 1, 1'b1);
        idle(0, 1);
        sample();
        chk("a_resume_count", int'(cnt_a), 4);
        for (int i = 0; i < 4; i++) pop(0);

        // B: odd parity error, then a framing error.
        qb.push_back(12'h803);
        send(1, 9'h003, 8, 1'b0, 1, 1, 1'b1);
        idle(1, 1);
        qb.push_back(12'h455);
        send(1, 9'h055, 8, 1'b1, 1, 1, 1'b0);
        idle(1, 2);
        pop(1);
        pop(1);

        // B: overflow at DEPTH=4, then OE on the next stored entry only.
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i * 17);
            if (i < 5) qb.push_back({4'h0, v});
            send(1, {1'b0, v}, 8, ~^v, 1, 1, 1'b1);
            idle(1, 1);
            if (i == 4) begin
                sample();
                chk("b_full_after4", int'(ff_b), 1);
                chk("b_count_after4", int'(cnt_b), 4);
            end
        end
        sample();
        chk("b_overrun_pulse", int'(ovr_b), 1);
        sample();
        chk("b_overrun_end", int'(ovr_b), 0);
        chk("b_count_after_drop", int'(cnt_b), 4);
        pop(1);
        v = 8'h66;
        qb.push_back(12'h166);
        send(1, {1'b0, v}, 8, ~^v, 1, 1, 1'b1);
        idle(1, 1);
        pop(1);
        v = 8'h77;
        qb.push_back(12'h077);
        send(1, {1'b0, v}, 8, ~^v, 1, 1, 1'b1);
        idle(1, 1);
        for (int i = 0; i < 4; i++) pop(1);
        sample();
        chk("b_count_drained", int'(cnt_b), 0);

        // B: full FIFO with a pop in every PUSH cycle; pointers wrap repeatedly.
        for (int i = 1; i <= 4; i++) begin
            v = 8'h80 + 8'(i);
            qb.push_back({4'h0, v});
            send(1, {1'b0, v}, 8, ~^v, 1, 1, 1'b1);
            idle(1, 1);
        end
        for (int i = 0; i < 11; i++) begin
            v = 8'hA0 + 8'(i);
            qb.push_back({4'h0, v});
            send(1, {1'b0, v}, 8, ~^v, 1, 1, 1'b1);
            pop(1);
            sample();
            chk("b_full_count", int'(cnt_b), 4);
            chk("b_full_no_overrun", int'(ovr_b), 0);
            chk("b_full_flag", int'(ff_b), 1);
        end
        for (int i = 0; i < 4; i++) pop(1);
        sample();
        chk("b_RxFE_end", int'(fe_b), 1);

        // C: 7 data bits, no parity, two stops; back-to-back frames.
        qc.push_back(12'h035);
        qc.push_back(12'h04A);
        send(2, 9'h035, 7, 1'b0, 0, 2, 1'b1);
        send(2, 9'h04A, 7, 1'b0, 0, 2, 1'b1);
        idle(2, 2);
        sample();
        chk("c_b2b_count", int'(cnt_c), 2);
        pop(2);
        pop(2);

        // C: reset in the middle of a frame with one entry still queued.
        send(2, 9'h011, 7, 1'b0, 0, 2, 1'b1);
        idle(2, 1);
        drive(2, 1'b0);
        drive(2, 1'b1);
        drive(2, 1'b0);
        drive(2, 1'b1);
        sample();
        chk("c_busy_mid", int'(busy_c), 1);
        chk("c_count_mid", int'(cnt_c), 1);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        sample();
        chk("c_rst_count", int'(cnt_c), 0);
        chk("c_rst_RxFE", int'(fe_c), 1);
        chk("c_rst_busy", int'(busy_c), 0);
        chk("c_rst_dout", int'(dout_c), 0);
        qc.push_back(12'h07F);
        send(2, 9'h07F, 7, 1'b0, 0, 2, 1'b1);
        idle(2, 2);
        pop(2);

        sample();
        sample();
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        chk("c_queue_empty", qc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
